// File: rtl/gray_pkg.sv
// gray_pkg: definitions shared by the Gray-code position tracker and the
// existing Gray-to-binary converter.
//   state_t    - tracker FSM states (INIT, TRACK, FAULT)
//   GRAY_W     - default Gray code width
//   DELTA_UP   - decoded difference meaning a +1 step
//   DELTA_DN   - decoded difference meaning a -1 step (2^GRAY_W - 1)
//   gray2bin() - width-independent Gray-to-binary decode
package gray_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int GRAY_W   = 4;
  localparam int DELTA_UP = 1;
  localparam int DELTA_DN = (1 << GRAY_W) - 1;

  // Binary bit i is the XOR of Gray bits i..MSB. Zero-extending a narrower
  // code leaves the extra upper bits zero, so the low bits of the result are
  // correct for any width up to 32; callers cast the result to their width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync_debounce.sv
// gray_sync_debounce: two-flop synchroniser followed by a stability counter.
// A code is accepted once it has been seen unchanged at the synchroniser
// output for STABLE consecutive cycles; accept fires exactly once per code.
//   clk, rst  - clock, synchronous active-high reset
//   en        - tracking enable; while low the stability count is held at 0
//   g_in      - asynchronous Gray code input
//   g_last    - last code seen at the synchroniser output
//   accept    - single-cycle strobe: g_last becomes stable on this edge
module gray_sync_debounce
  import gray_pkg::*;
#(
  parameter int W      = GRAY_W,
  parameter int STABLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] g_in,
  output logic [W-1:0] g_last,
  output logic         accept
);

  localparam int SW = $clog2(STABLE + 1);

  logic [W-1:0]  g_s1_q, g_s1_d;
  logic [W-1:0]  g_s2_q, g_s2_d;
  logic [W-1:0]  g_last_q, g_last_d;
  logic [SW-1:0] stab_q, stab_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    g_s1_d   = g_in;
    g_s2_d   = g_s1_q;
    g_last_d = g_last_q;
    stab_d   = stab_q;
    if (g_s2_q != g_last_q) begin
      g_last_d = g_s2_q;
      stab_d   = en ? SW'(1) : '0;
    end else if (!en) begin
      stab_d = '0;
    end else if (stab_q < SW'(STABLE)) begin
      stab_d = stab_q + SW'(1);
    end
  end

  // Fires on the edge where the count steps from STABLE-1 to STABLE; the
  // count then saturates, so a held code never fires again.
  assign accept = en && (g_s2_q == g_last_q) && (stab_q == SW'(STABLE - 1));
  assign g_last = g_last_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_s1_q   <= '0;
      g_s2_q   <= '0;
      g_last_q <= '0;
      stab_q   <= '0;
    end else begin
      g_s1_q   <= g_s1_d;
      g_s2_q   <= g_s2_d;
      g_last_q <= g_last_d;
      stab_q   <= stab_d;
    end
  end

endmodule

// File: rtl/gray_step_tracker.sv
// gray_step_tracker: tracks a debounced Gray-coded position input, decodes
// it, classifies each accepted change as +1 / -1 / illegal, maintains a
// signed position and offers a one-deep step event over valid/ready.
//   clk, rst    - clock, synchronous active-high reset
//   en          - tracking enable
//   g_in        - asynchronous Gray code input
//   err_clr     - pulse: clears err and ovf, leaves FAULT for INIT
//   step_ready  - consumer accepts the pending step event
//   bin         - binary value of the last accepted code
//   pos         - signed position, wraps modulo 2^POS_W
//   step_valid  - step event pending
//   step_dir    - 1 = +1 step, 0 = -1 step (meaningful while step_valid)
//   err         - sticky illegal-transition fault
//   ovf         - sticky step-event overrun
module gray_step_tracker
  import gray_pkg::*;
#(
  parameter int W      = GRAY_W,
  parameter int STABLE = 4,
  parameter int POS_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     g_in,
  input  logic             err_clr,
  input  logic             step_ready,
  output logic [W-1:0]     bin,
  output logic [POS_W-1:0] pos,
  output logic             step_valid,
  output logic             step_dir,
  output logic             err,
  output logic             ovf
);

  logic [W-1:0] g_last;
  logic         accept;

  gray_sync_debounce #(
    .W      (W),
    .STABLE (STABLE)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .g_in   (g_in),
    .g_last (g_last),
    .accept (accept)
  );

  state_t           state_q, state_d;
  logic [W-1:0]     ref_q, ref_d;
  logic [W-1:0]     bin_q, bin_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             step_valid_q, step_valid_d;
  logic             step_dir_q, step_dir_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic [W-1:0] b;
  logic [W-1:0] delta;
  logic         step_new;
  logic         step_new_dir;

  assign b     = W'(gray2bin(32'(g_last)));
  assign delta = b - ref_q;

  always_comb begin
    state_d      = state_q;
    ref_d        = ref_q;
    bin_d        = bin_q;
    pos_d        = pos_q;
    step_valid_d = step_valid_q;
    step_dir_d   = step_dir_q;
    err_d        = err_q;
    ovf_d        = ovf_q;
    step_new     = 1'b0;
    step_new_dir = 1'b0;

    if (!en) begin
      state_d      = INIT;
      step_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          if (accept) begin
            ref_d   = b;
            bin_d   = b;
            state_d = TRACK;
          end
        end
        TRACK: begin
          if (accept) begin
            ref_d = b;
            bin_d = b;
            if (delta == W'(DELTA_UP)) begin
              pos_d        = pos_q + POS_W'(1);
              step_new     = 1'b1;
              step_new_dir = 1'b1;
            end else if (delta == {W{1'b1}}) begin
              // All ones is 2^W-1, i.e. DELTA_DN at this width.
              pos_d        = pos_q - POS_W'(1);
              step_new     = 1'b1;
              step_new_dir = 1'b0;
            end else if (delta != '0) begin
              err_d   = 1'b1;
              state_d = FAULT;
            end
          end
        end
        FAULT: begin
          // err_clr wins over a coincident accept, which is simply dropped.
          if (err_clr) begin
            err_d   = 1'b0;
            state_d = INIT;
          end
        end
        default: state_d = INIT;
      endcase

      // One-deep buffer: a completed handshake frees the slot on this same
      // edge, so a coincident new step reloads it instead of overrunning.
      if (step_valid_q && step_ready) begin
        step_valid_d = 1'b0;
      end
      if (step_new) begin
        if (!step_valid_q || step_ready) begin
          step_valid_d = 1'b1;
          step_dir_d   = step_new_dir;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    if (err_clr) begin
      err_d = 1'b0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      ref_q        <= '0;
      bin_q        <= '0;
      pos_q        <= '0;
      step_valid_q <= 1'b0;
      step_dir_q   <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ref_q        <= ref_d;
      bin_q        <= bin_d;
      pos_q        <= pos_d;
      step_valid_q <= step_valid_d;
      step_dir_q   <= step_dir_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bin        = bin_q;
  assign pos        = pos_q;
  assign step_valid = step_valid_q;
  assign step_dir   = step_dir_q;
  assign err        = err_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_gray_step_tracker.sv
// Directed bench for gray_step_tracker. A second instance with a 4-bit
// position counter shares all inputs so the signed wrap points can be
// reached in a handful of steps.
module tb_gray_step_tracker;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  g_in;
  logic        err_clr;
  logic        step_ready;

  logic [3:0]  bin;
  logic [15:0] pos;
  logic        step_valid;
  logic        step_dir;
  logic        err;
  logic        ovf;

  logic [3:0]  bin4;
  logic [3:0]  pos4;
  logic        step_valid4;
  logic        step_dir4;
  logic        err4;
  logic        ovf4;

  int checks   = 0;
  int failures = 0;
  logic seen_valid;

  gray_step_tracker #(.W(4), .STABLE(4), .POS_W(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .g_in       (g_in),
    .err_clr    (err_clr),
    .step_ready (step_ready),
    .bin        (bin),
    .pos        (pos),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .err        (err),
    .ovf        (ovf)
  );

  gray_step_tracker #(.W(4), .STABLE(4), .POS_W(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .g_in       (g_in),
    .err_clr    (err_clr),
    .step_ready (step_ready),
    .bin        (bin4),
    .pos        (pos4),
    .step_valid (step_valid4),
    .step_dir   (step_dir4),
    .err        (err4),
    .ovf        (ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Binary-to-Gray encode used to drive the stimulus.
  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] bb;
    bb = 4'(b);
    return bb ^ (bb >> 1);
  endfunction

  // Present the Gray code of b and expect one step event, assuming
  // step_ready=1: accepted on the 6th edge, event gone on the 7th.
  task automatic step_to(input int b, input logic exp_dir, input logic [15:0] exp_pos);
    g_in = to_gray(b);
    repeat (5) @(negedge clk);
    check("step_early", 32'(step_valid), 32'(0));
    @(negedge clk);
    check("step_valid", 32'(step_valid), 32'(1));
    check("step_dir", 32'(step_dir), 32'(exp_dir));
    check("step_pos", 32'(pos), 32'(exp_pos));
    check("step_bin", 32'(bin), 32'(b[3:0]));
    @(negedge clk);
    check("step_drop", 32'(step_valid), 32'(0));
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    g_in       = 4'b0000;
    err_clr    = 1'b0;
    step_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_bin", 32'(bin), 32'(0));
    check("rst_pos", 32'(pos), 32'(0));
    check("rst_valid", 32'(step_valid), 32'(0));
    check("rst_dir", 32'(step_dir), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));

    // Hold 0000: INIT references silently.
    rst = 1'b0;
    en  = 1'b1;
    seen_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen_valid |= step_valid;
    end
    check("init_no_event", 32'(seen_valid), 32'(0));
    check("init_pos", 32'(pos), 32'(0));
    check("init_bin", 32'(bin), 32'(0));

    // Upward walk through all sixteen codes, wrapping back to 0000.
    for (int i = 1; i <= 16; i++) begin
      step_to(i % 16, 1'b1, 16'(i));
      if (i == 7) check("pos4_max", 32'(pos4), 32'(7));
      if (i == 8) check("pos4_wrap_min", 32'(pos4), 32'(8));
    end
    check("up_pos", 32'(pos), 32'(16));
    check("up_bin", 32'(bin), 32'(0));

    // Downward walk back to zero, then one more step below zero and back.
    for (int i = 15; i >= 0; i--) begin
      step_to(i, 1'b0, 16'(i));
    end
    check("dn_pos", 32'(pos), 32'(0));
    step_to(15, 1'b0, 16'hFFFF);
    check("pos4_under", 32'(pos4), 32'(4'hF));
    step_to(0, 1'b1, 16'h0000);

    // Glitch rejection: 0011 for two clocks then back to 0001.
    step_to(1, 1'b1, 16'd1);
    seen_valid = 1'b0;
    g_in = 4'b0011;
    repeat (2) begin
      @(negedge clk);
      seen_valid |= step_valid;
    end
    g_in = 4'b0001;
    repeat (10) begin
      @(negedge clk);
      seen_valid |= step_valid;
    end
    check("glitch_no_event", 32'(seen_valid), 32'(0));
    check("glitch_pos", 32'(pos), 32'(1));
    check("glitch_err", 32'(err), 32'(0));

    // Overrun: two up-steps with the consumer stalled.
    step_ready = 1'b0;
    g_in = to_gray(2);
    repeat (6) @(negedge clk);
    check("ovr_first_valid", 32'(step_valid), 32'(1));
    check("ovr_first_pos", 32'(pos), 32'(2));
    check("ovr_first_ovf", 32'(ovf), 32'(0));
    repeat (2) @(negedge clk);
    g_in = to_gray(3);
    repeat (6) @(negedge clk);
    check("ovr_held_valid", 32'(step_valid), 32'(1));
    check("ovr_held_dir", 32'(step_dir), 32'(1));
    check("ovr_pos", 32'(pos), 32'(3));
    check("ovr_flag", 32'(ovf), 32'(1));
    step_ready = 1'b1;
    @(negedge clk);
    check("ovr_drain", 32'(step_valid), 32'(0));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovr_clear", 32'(ovf), 32'(0));

    // Reload: handshake completes on the same edge as a new down-step.
    step_ready = 1'b0;
    g_in = to_gray(4);
    repeat (6) @(negedge clk);
    check("rld_first_valid", 32'(step_valid), 32'(1));
    check("rld_first_pos", 32'(pos), 32'(4));
    repeat (2) @(negedge clk);
    g_in = to_gray(3);
    repeat (5) @(negedge clk);
    step_ready = 1'b1;
    @(negedge clk);
    check("rld_valid", 32'(step_valid), 32'(1));
    check("rld_dir", 32'(step_dir), 32'(0));
    check("rld_pos", 32'(pos), 32'(3));
    check("rld_ovf", 32'(ovf), 32'(0));
    @(negedge clk);
    check("rld_drop", 32'(step_valid), 32'(0));
    @(negedge clk);

    // Illegal transition 1 -> 3, fault freeze, clear and re-reference.
    step_to(2, 1'b0, 16'd2);
    step_to(1, 1'b0, 16'd1);
    g_in = to_gray(3);
    repeat (6) @(negedge clk);
    check("flt_err", 32'(err), 32'(1));
    check("flt_pos", 32'(pos), 32'(1));
    check("flt_valid", 32'(step_valid), 32'(0));
    check("flt_bin", 32'(bin), 32'(3));
    repeat (2) @(negedge clk);
    g_in = to_gray(5);
    repeat (8) @(negedge clk);
    check("flt_ignored_bin", 32'(bin), 32'(3));
    check("flt_ignored_pos", 32'(pos), 32'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("flt_clear", 32'(err), 32'(0));
    seen_valid = 1'b0;
    g_in = 4'b0110;
    repeat (8) begin
      @(negedge clk);
      seen_valid |= step_valid;
    end
    check("reref_bin", 32'(bin), 32'(4));
    check("reref_pos", 32'(pos), 32'(1));
    check("reref_no_event", 32'(seen_valid), 32'(0));
    step_to(5, 1'b1, 16'd2);

    // Disable holds pos/bin; re-enable re-references, then tracks again.
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("dis_valid", 32'(step_valid), 32'(0));
    check("dis_pos", 32'(pos), 32'(2));
    check("dis_bin", 32'(bin), 32'(5));
    en = 1'b1;
    repeat (8) @(negedge clk);
    step_to(6, 1'b1, 16'd3);

    // Reset while an event is pending clears every output.
    step_ready = 1'b0;
    g_in = to_gray(7);
    repeat (6) @(negedge clk);
    check("pend_valid", 32'(step_valid), 32'(1));
    check("pend_pos", 32'(pos), 32'(4));
    rst = 1'b1;
    @(negedge clk);
    check("rst2_bin", 32'(bin), 32'(0));
    check("rst2_pos", 32'(pos), 32'(0));
    check("rst2_valid", 32'(step_valid), 32'(0));
    check("rst2_dir", 32'(step_dir), 32'(0));
    check("rst2_err", 32'(err), 32'(0));
    check("rst2_ovf", 32'(ovf), 32'(0));
    check("rst2_bin4", 32'(bin4), 32'(0));
    check("rst2_pos4", 32'(pos4), 32'(0));
    check("rst2_valid4", 32'(step_valid4), 32'(0));
    check("rst2_dir4", 32'(step_dir4), 32'(0));
    check("rst2_err4", 32'(err4), 32'(0));
    check("rst2_ovf4", 32'(ovf4), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
